// File: rtl/full_subtractor_behi_ifelse.sv
// -----------------------------------------------------------------------------
// full_subtractor_behi_ifelse
//
// 1-bit full subtractor with a combinational datapath and a registered
// bit-serial subtraction engine. The combinational Diff/Borr pair works as a
// standalone full-subtractor cell. With en/chain asserted, the block performs a
// WIDTH-bit, LSB-first serial subtraction A-B. It chains its own registered
// borrow between bits.
//
// Optional feature (compile-time macro FS_BORR_CNT_EN):
//   When defined, the block adds output borr_cnt[7:0]. This counter saturates
//   at 255 and counts the enabled clock edges on which Borr is 1.
//
// Parameters:
//   WIDTH    - bits per serial subtraction word (>= 2), default 8
//
// Ports:
//   clk      in   1      rising-edge clock
//   rst      in   1      asynchronous, active-high reset
//   A        in   1      minuend bit
//   B        in   1      subtrahend bit
//   Bin      in   1      external borrow-in (always used for bit 0 of a word)
//   en       in   1      capture/advance enable
//   chain    in   1      1 = serial mode, chain the registered borrow
//   Diff     out  1      combinational difference
//   Borr     out  1      combinational borrow-out
//   diff_q   out  1      registered Diff
//   borr_q   out  1      registered Borr (final borrow-out at word end)
//   vld_q    out  1      registered-output valid
//   result_q out  WIDTH  serial result shift register (LSB shifted in first)
//   borr_cnt out  8      saturating borrow counter (FS_BORR_CNT_EN only)
//   done_q   out  1      one-cycle pulse: word complete
// -----------------------------------------------------------------------------
module full_subtractor_behi_ifelse #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             A,
    input  logic             B,
    input  logic             Bin,
    input  logic             en,
    input  logic             chain,
    output logic             Diff,
    output logic             Borr,
    output logic             diff_q,
    output logic             borr_q,
    output logic             vld_q,
    output logic [WIDTH-1:0] result_q,
`ifdef FS_BORR_CNT_EN
    output logic [7:0]       borr_cnt,
`endif
    output logic             done_q
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    logic [CNT_W-1:0] bit_cnt;
    logic             bin_eff;

    // Borrow-in selection plus the full-subtractor equations. The first bit of
    // every word takes the external Bin, so a serial word can start with an
    // initial borrow.
    always_comb begin
        // NOTE: every output of a combinational block gets a value on every
        // path; a missing else branch would infer a latch.
        bin_eff = Bin;
        if (chain && (bit_cnt != '0)) begin
            bin_eff = borr_q;
        end else begin
            bin_eff = Bin;
        end

        Diff = A ^ B ^ bin_eff;
        Borr = (~A & B) | (~A & bin_eff) | (B & bin_eff);
    end

    // Serial engine state. An idle cycle (en=0) keeps the partial word. This
    // allows gaps inside a word. The valid and done strobes drop for that cycle.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so that every
        // register samples values from before the edge, whatever the order of
        // the statements.
        if (rst) begin
            diff_q   <= 1'b0;
            borr_q   <= 1'b0;
            vld_q    <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            bit_cnt  <= '0;
        end else if (en) begin
            diff_q   <= Diff;
            borr_q   <= Borr;
            vld_q    <= 1'b1;
            result_q <= {Diff, result_q[WIDTH-1:1]};
            if (bit_cnt == LAST_BIT) begin
                bit_cnt <= '0;
                done_q  <= 1'b1;
            end else begin
                bit_cnt <= bit_cnt + 1'b1;
                done_q  <= 1'b0;
            end
        end else begin
            vld_q  <= 1'b0;
            done_q <= 1'b0;
        end
    end

`ifdef FS_BORR_CNT_EN
    // Counts enabled edges that produced a borrow. The counter holds at
    // all-ones instead of wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            borr_cnt <= 8'd0;
        end else if (en && Borr && (borr_cnt != 8'hFF)) begin
            borr_cnt <= borr_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_full_subtractor_behi_ifelse.sv
// -----------------------------------------------------------------------------
// tb_full_subtractor_behi_ifelse
//
// Self-checking bench for full_subtractor_behi_ifelse (WIDTH = 8).
// It checks the combinational truth table, serial words, a reset in the middle
// of a word, and an enable gap inside a word. When FS_BORR_CNT_EN is defined,
// it also checks the saturating borrow counter.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_full_subtractor_behi_ifelse;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             A;
    logic             B;
    logic             Bin;
    logic             en;
    logic             chain;
    logic             Diff;
    logic             Borr;
    logic             diff_q;
    logic             borr_q;
    logic             vld_q;
    logic [WIDTH-1:0] result_q;
    logic             done_q;
`ifdef FS_BORR_CNT_EN
    logic [7:0]       borr_cnt;
`endif

    int n_checks = 0;
    int n_fails  = 0;

    full_subtractor_behi_ifelse #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .A        (A),
        .B        (B),
        .Bin      (Bin),
        .en       (en),
        .chain    (chain),
        .Diff     (Diff),
        .Borr     (Borr),
        .diff_q   (diff_q),
        .borr_q   (borr_q),
        .vld_q    (vld_q),
        .result_q (result_q),
`ifdef FS_BORR_CNT_EN
        .borr_cnt (borr_cnt),
`endif
        .done_q   (done_q)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Combinational truth-table vector.
    typedef struct {
        logic a;
        logic b;
        logic bin;
        logic diff;
        logic borr;
    } comb_vec_t;

    // Serial word vector with hand-computed result and final borrow.
    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       bin0;
        logic [7:0] res;
        logic       borr;
    } word_vec_t;

    // Feeds one word LSB-first. Inputs change on the falling edge. If gap_at
    // matches a bit index, en drops for two cycles before that bit.
    task automatic feed_word(input word_vec_t v, input int gap_at);
        logic [WIDTH-1:0] saved;
        logic             saved_borr;
        for (int i = 0; i < WIDTH; i++) begin
            @(negedge clk);
            if (i == gap_at) begin
                en = 1'b0;
                saved      = result_q;
                saved_borr = borr_q;
                @(negedge clk);
                @(negedge clk);
                check("gap_vld",    32'(vld_q),    32'(1'b0));
                check("gap_done",   32'(done_q),   32'(1'b0));
                check("gap_result", 32'(result_q), 32'(saved));
                check("gap_borr",   32'(borr_q),   32'(saved_borr));
            end
            if (i == WIDTH - 1) begin
                check("pre_last_done", 32'(done_q), 32'(1'b0));
            end
            A     = v.a[i];
            B     = v.b[i];
            // Outside bit 0, Bin is set opposite to bin0. With chain=1, it must
            // be ignored.
            Bin   = (i == 0) ? v.bin0 : ~v.bin0;
            chain = 1'b1;
            en    = 1'b1;
        end
        @(negedge clk);
        en = 1'b0;
        check("word_done",   32'(done_q),   32'(1'b1));
        check("word_vld",    32'(vld_q),    32'(1'b1));
        check("word_result", 32'(result_q), 32'(v.res));
        check("word_borr",   32'(borr_q),   32'(v.borr));
        @(negedge clk);
        check("done_pulse_end", 32'(done_q), 32'(1'b0));
    endtask

    initial begin
        comb_vec_t comb_tbl[8];
        word_vec_t word_tbl[4];

        comb_tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        comb_tbl[1] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        comb_tbl[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        comb_tbl[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        comb_tbl[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        comb_tbl[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        comb_tbl[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        comb_tbl[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

        word_tbl[0] = '{8'h35, 8'h17, 1'b0, 8'h1E, 1'b0};
        word_tbl[1] = '{8'h10, 8'h20, 1'b0, 8'hF0, 1'b1};
        word_tbl[2] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1};
        word_tbl[3] = '{8'hA7, 8'h5C, 1'b0, 8'h4B, 1'b0};

        clk = 1'b0; rst = 1'b1; A = 1'b0; B = 1'b0; Bin = 1'b0;
        en = 1'b0; chain = 1'b0;

        // Reset state.
        #3;
        check("rst_diff_q",   32'(diff_q),   32'(1'b0));
        check("rst_borr_q",   32'(borr_q),   32'(1'b0));
        check("rst_vld_q",    32'(vld_q),    32'(1'b0));
        check("rst_done_q",   32'(done_q),   32'(1'b0));
        check("rst_result_q", 32'(result_q), 32'(0));

        // Combinational sweep while reset is held.
        for (int i = 0; i < 8; i++) begin
            A   = comb_tbl[i].a;
            B   = comb_tbl[i].b;
            Bin = comb_tbl[i].bin;
            #5;
            check($sformatf("comb_diff_%0d", i), 32'(Diff), 32'(comb_tbl[i].diff));
            check($sformatf("comb_borr_%0d", i), 32'(Borr), 32'(comb_tbl[i].borr));
        end

        @(negedge clk);
        rst = 1'b0;

        // Serial words back to back.
        for (int i = 0; i < 4; i++) begin
            feed_word(word_tbl[i], -1);
        end

        // Reset in the middle of a word. Three bits of 0x35-0x17 are fed,
        // then rst rises between edges.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            A = word_tbl[0].a[i]; B = word_tbl[0].b[i]; Bin = 1'b0;
            chain = 1'b1; en = 1'b1;
        end
        @(negedge clk);
        en = 1'b0;
        check("mid_pre_rst_vld", 32'(vld_q), 32'(1'b1));
        #1 rst = 1'b1;
        #1;
        check("mid_rst_result", 32'(result_q), 32'(0));
        check("mid_rst_vld",    32'(vld_q),    32'(1'b0));
        check("mid_rst_borr",   32'(borr_q),   32'(1'b0));
        check("mid_rst_diff",   32'(diff_q),   32'(1'b0));
        @(negedge clk);
        rst = 1'b0;
        feed_word('{8'h05, 8'h03, 1'b0, 8'h02, 1'b0}, -1);

        // Enable gap inside a word.
        feed_word('{8'h35, 8'h17, 1'b0, 8'h1E, 1'b0}, 4);
        feed_word('{8'h10, 8'h20, 1'b0, 8'hF0, 1'b1}, 1);

`ifdef FS_BORR_CNT_EN
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("cnt_rst0", 32'(borr_cnt), 32'(0));
        @(negedge clk);
        rst = 1'b0; A = 1'b0; B = 1'b1; Bin = 1'b0; chain = 1'b0; en = 1'b1;
        for (int i = 0; i < 10; i++) @(negedge clk);
        check("cnt_10", 32'(borr_cnt), 32'(10));
        for (int i = 10; i < 300; i++) @(negedge clk);
        check("cnt_sat", 32'(borr_cnt), 32'(255));
        en = 1'b0;
        #1 rst = 1'b1;
        #1;
        check("cnt_rst", 32'(borr_cnt), 32'(0));
        @(negedge clk);
        rst = 1'b0;
`endif

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
